mult_req_sequencer: RTL

- Upstream front-end for array_multiplier_top.
- Accepts operand pairs on a valid/ready handshake and drives the multiplier's EA/EB/A_in/B_in pins with correct load timing.
- Waits the multiplier's fixed latency, captures P_out, and buffers products in a small result FIFO with a valid/ready output handshake.
- Decouples the multiplier's enable-pulse interface from streaming producers and consumers.

---
 rtl/mult_seq_pkg.sv | 19 +
 rtl/mult_result_fifo.sv | 57 +++++
 rtl/mult_req_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the multiplier request sequencer.
package mult_seq_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_MUL_LAT    = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } seq_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Synchronous result FIFO. Head is shown on `head` (zero when empty);
// pop when empty is ignored, push and pop together keep count unchanged.
module mult_result_fifo
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; empty entries are never visible because head is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mult_req_sequencer.sv
// Streaming front-end for array_multiplier_top: accepts operand pairs,
// pulses EA/EB for one cycle, waits MUL_LAT edges, captures P_out into a
// result FIFO. Optional build macro MULT_SEQ_CHECK_EN adds a product
// self-check that drives the sticky err_flag.
module mult_req_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    mul_ea,
  output logic                    mul_eb,
  output logic [DATA_WIDTH-1:0]   mul_a,
  output logic [DATA_WIDTH-1:0]   mul_b,
  input  logic [2*DATA_WIDTH-1:0] mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_p,
  output logic                    busy,
  output logic                    err_flag
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = fifo_cnt_w(FIFO_DEPTH);
  localparam int LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(MUL_LAT - 1);

  seq_state_e    state;
  seq_state_e    state_next;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_next;
  logic          accept;
  logic          capture;
  logic [CW-1:0] fifo_count;

  // Ready depends only on registered state and FIFO occupancy, so no
  // combinational path exists from in_valid or out_ready. Holding one free
  // slot per accepted pair guarantees the capture never overflows.
  assign in_ready = rst_n && (state == S_IDLE) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // Next-state and capture decode for the single in-flight operation.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      S_IDLE: if (accept) state_next = S_LOAD;
      S_LOAD: begin
        state_next = S_WAIT;
        cnt_next   = LAT_INIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - LW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, latency counter, registered enable pulse and held operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mul_ea <= 1'b0;
      mul_eb <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      mul_ea <= (state_next == S_LOAD);
      mul_eb <= (state_next == S_LOAD);
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
    end
  end

  mult_result_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (mul_p),
    .pop       (out_ready),
    .head      (out_p),
    .count     (fifo_count),
    .valid     (out_valid)
  );

`ifdef MULT_SEQ_CHECK_EN
  logic [PW-1:0] ref_p;
  logic          err_q;

  assign ref_p = PW'(mul_a) * PW'(mul_b);

  // Sticky flag raised when the captured product disagrees with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture && (mul_p != ref_p)) begin
      err_q <= 1'b1;
      $error("mult_req_sequencer: product %0d != %0d*%0d", mul_p, mul_a, mul_b);
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule
